// File: rtl/lstm_feed_pkg.sv
// Shared definitions for the systolic feed sequencer: FSM state encoding
// and the default job/word sizing used by the top-level parameters.
package lstm_feed_pkg;

    localparam int NUM_WAVES_DEF = 15;
    localparam int DATA_W_DEF    = 64;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_VALID = 3'd2,
        S_WAIT_CLEAR = 3'd3,
        S_DRAIN      = 3'd4
    } feed_state_e;

endpackage

// File: rtl/feed_fifo2.sv
// Two-entry first-word-fall-through FIFO.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, wr_data   write strobe and word
//   pop             read strobe (head advances on pop while not empty)
//   rd_data         head word, forced to zero while empty
//   full, empty     occupancy flags
//   count           occupancy 0..2
module feed_fifo2 #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign count = count_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // The write is suppressed when full so storage can never be corrupted;
    // the sequencer guarantees this case does not arise.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/systolic_feed_sequencer.sv
// Sequences one job of NUM_WAVES diagonal waves: requests each wave from the
// A-input extractor, captures its result into a 2-entry FIFO and streams the
// words to the systolic array with valid/ready handshaking.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   job_start / job_busy / job_done   job control
//   ext_start, ext_cycle        extractor request and wave index
//   ext_a_flat, ext_valid       extractor result word and valid level
//   out_data, out_last, out_valid, out_ready   array-side stream
//
// state        | meaning
// S_IDLE       | no job; waiting for job_start
// S_ISSUE      | waiting for FIFO room, then pulses ext_start
// S_WAIT_VALID | request in flight; first ext_valid pushes the word
// S_WAIT_CLEAR | waiting for ext_valid to drop before the next wave
// S_DRAIN      | all waves pushed; waiting for the FIFO to empty
module systolic_feed_sequencer
    import lstm_feed_pkg::*;
#(
    parameter int NUM_WAVES = NUM_WAVES_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_start,
    output logic              job_busy,
    output logic              job_done,
    output logic              ext_start,
    output logic [3:0]        ext_cycle,
    input  logic [DATA_W-1:0] ext_a_flat,
    input  logic              ext_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [3:0] LAST_WAVE = 4'(NUM_WAVES - 1);

    feed_state_e state_q, state_d;
    logic [3:0]  wave_q, wave_d;
    logic        inflight_q, inflight_d;

    logic        push;
    logic        pop;
    logic [DATA_W:0] fifo_rd;
    logic        fifo_full;
    logic        fifo_empty;
    logic [1:0]  fifo_count;
    logic        can_issue;

    // Buffered words plus the outstanding request must fit in the FIFO,
    // which is what makes a push into a full FIFO unreachable.
    assign can_issue = !fifo_full &&
                       (({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2);

    assign pop       = out_valid && out_ready;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rd[DATA_W:1];
    assign out_last  = fifo_rd[0];
    assign ext_cycle = wave_q;

    assign job_done  = (state_q == S_DRAIN) && fifo_empty;
    assign job_busy  = (state_q != S_IDLE) && !job_done;

    always_comb begin
        state_d    = state_q;
        wave_d     = wave_q;
        inflight_d = inflight_q;
        ext_start  = 1'b0;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (job_start) begin
                    wave_d  = 4'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (can_issue) begin
                    ext_start  = 1'b1;
                    inflight_d = 1'b1;
                    state_d    = S_WAIT_VALID;
                end
            end
            S_WAIT_VALID: begin
                if (ext_valid) begin
                    push       = 1'b1;
                    inflight_d = 1'b0;
                    state_d    = S_WAIT_CLEAR;
                end
            end
            S_WAIT_CLEAR: begin
                if (!ext_valid) begin
                    if (wave_q == LAST_WAVE) begin
                        state_d = S_DRAIN;
                    end else begin
                        wave_d  = wave_q + 4'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wave_q     <= 4'd0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wave_q     <= wave_d;
            inflight_q <= inflight_d;
        end
    end

    feed_fifo2 #(
        .W (DATA_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data ({ext_a_flat, (wave_q == LAST_WAVE)}),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_systolic_feed_sequencer.sv
// Directed bench for systolic_feed_sequencer with a simple extractor model
// that answers each ext_start after a programmable delay and hold length.
module tb_systolic_feed_sequencer;

    localparam int NW = 15;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          job_start = 1'b0;
    logic          ext_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] ext_a_flat = '0;
    logic          job_busy, job_done, ext_start, out_last, out_valid;
    logic [3:0]    ext_cycle;
    logic [DW-1:0] out_data;

    systolic_feed_sequencer #(.NUM_WAVES(NW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .job_start  (job_start),
        .job_busy   (job_busy),
        .job_done   (job_done),
        .ext_start  (ext_start),
        .ext_cycle  (ext_cycle),
        .ext_a_flat (ext_a_flat),
        .ext_valid  (ext_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_vec = 0;
    int n_miscmp = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [3:0] c);
        return {16{c}} ^ 64'hA5A5_0000_5A5A_FFFF;
    endfunction

    // extractor model
    int         ext_delay = 3;
    int         hold_len  = 1;
    int         delay_left = 0;
    int         hold_left  = 0;
    logic [3:0] lat_cyc = '0;
    int         n_starts = 0;
    logic [3:0] start_log[$];

    initial forever begin
        @(negedge clk);
        if (rst) begin
            delay_left = 0;
            hold_left  = 0;
            ext_valid  = 1'b0;
        end else begin
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) ext_valid = 1'b0;
            end
            if (delay_left > 0) begin
                delay_left--;
                if (delay_left == 0) begin
                    ext_valid  = 1'b1;
                    ext_a_flat = pat(lat_cyc);
                    hold_left  = hold_len;
                end
            end
            if (ext_start) begin
                lat_cyc    = ext_cycle;
                delay_left = ext_delay;
                n_starts++;
                start_log.push_back(ext_cycle);
            end
        end
    end

    // output monitor
    logic [DW-1:0] beat_data[$];
    logic          beat_last[$];
    int            last_xfer_cyc = 0;
    int            done_cyc = 0;
    int            n_done = 0;
    logic          busy_at_done = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (out_valid && out_ready) begin
                beat_data.push_back(out_data);
                beat_last.push_back(out_last);
                last_xfer_cyc = cyc;
            end
            if (job_done) begin
                n_done++;
                done_cyc     = cyc;
                busy_at_done = job_busy;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        beat_data.delete();
        beat_last.delete();
        start_log.delete();
        n_starts = 0;
        n_done   = 0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        job_start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic pulse_start();
        job_start = 1'b1;
        tick();
        job_start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},      64'(job_busy),  64'd0);
        chk({tag, "_done"},      64'(job_done),  64'd0);
        chk({tag, "_ext_start"}, 64'(ext_start), 64'd0);
        chk({tag, "_ext_cycle"}, 64'(ext_cycle), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_last"},  64'(out_last),  64'd0);
        chk({tag, "_out_data"},  out_data,       64'd0);
    endtask

    task automatic wait_done(input int max, input string tag);
        int n0 = n_done;
        int k  = 0;
        while (n_done == n0 && k < max) begin
            tick();
            k++;
        end
        chk({tag, "_done_seen"}, 64'(n_done > n0), 64'd1);
    endtask

    task automatic wait_wave(input logic [3:0] w, input string tag);
        int k = 0;
        while (ext_cycle != w && k < 300) begin
            tick();
            k++;
        end
        chk({tag, "_reach_wave"}, 64'(ext_cycle), 64'(w));
    endtask

    task automatic check_job(input string tag);
        repeat (5) tick();
        chk({tag, "_beats"},  64'(beat_data.size()), 64'(NW));
        chk({tag, "_starts"}, 64'(n_starts), 64'(NW));
        chk({tag, "_ndone"},  64'(n_done), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
        for (int k = 0; k < NW; k++) begin
            logic [DW-1:0] d = (k < beat_data.size()) ? beat_data[k] : 'x;
            logic          l = (k < beat_last.size()) ? beat_last[k] : 1'bx;
            logic [3:0]    s = (k < start_log.size()) ? start_log[k] : 4'hx;
            chk({tag, "_data"},  d, pat(4'(k)));
            chk({tag, "_last"},  64'(l), 64'(k == NW - 1));
            chk({tag, "_cycle"}, 64'(s), 64'(k));
        end
        chk({tag, "_idle_busy"}, 64'(job_busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;

        // reset state
        do_reset();
        check_reset_outputs("rst");

        // no-stall job
        ext_delay = 3;
        hold_len  = 1;
        out_ready = 1'b1;
        pulse_start();
        chk("ns_busy_set", 64'(job_busy), 64'd1);
        chk("ns_first_start", 64'(ext_start), 64'd1);
        chk("ns_first_cycle", 64'(ext_cycle), 64'd0);
        tick();
        chk("ns_start_once", 64'(ext_start), 64'd0);
        wait_done(400, "ns");
        chk("ns_done_latency", 64'(done_cyc - last_xfer_cyc), 64'd1);
        check_job("ns");

        // backpressure: only two waves may be outstanding
        do_reset();
        out_ready = 1'b0;
        pulse_start();
        repeat (40) tick();
        chk("bp_starts", 64'(n_starts), 64'd2);
        chk("bp_no_beats", 64'(beat_data.size()), 64'd0);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_head", out_data, pat(4'd0));
        chk("bp_head_last", 64'(out_last), 64'd0);
        chk("bp_wave", 64'(ext_cycle), 64'd2);
        chk("bp_no_start", 64'(ext_start), 64'd0);
        repeat (5) tick();
        chk("bp_stable", out_data, pat(4'd0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (10) tick();
        chk("bp_starts_after_pop", 64'(n_starts), 64'd3);
        chk("bp_beats_after_pop", 64'(beat_data.size()), 64'd1);
        chk("bp_head_after_pop", out_data, pat(4'd1));
        out_ready = 1'b1;
        wait_done(400, "bp");
        check_job("bp");

        // push and pop in the same cycle with one entry buffered
        do_reset();
        out_ready = 1'b0;
        pulse_start();
        k = 0;
        while (n_starts < 2 && k < 50) begin
            tick();
            k++;
        end
        chk("pp_second_start", 64'(n_starts), 64'd2);
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pp_beats", 64'(beat_data.size()), 64'd1);
        chk("pp_valid", 64'(out_valid), 64'd1);
        chk("pp_head", out_data, pat(4'd1));
        repeat (10) tick();
        chk("pp_third_start", 64'(n_starts), 64'd3);
        out_ready = 1'b1;
        wait_done(400, "pp");
        check_job("pp");

        // ext_valid held for three cycles per wave
        do_reset();
        hold_len  = 3;
        out_ready = 1'b1;
        pulse_start();
        wait_done(600, "hold");
        check_job("hold");
        hold_len = 1;

        // job_start while busy is ignored
        do_reset();
        out_ready = 1'b1;
        pulse_start();
        wait_wave(4'd5, "ign");
        pulse_start();
        chk("ign_cycle", 64'(ext_cycle), 64'd5);
        chk("ign_busy", 64'(job_busy), 64'd1);
        wait_done(400, "ign");
        check_job("ign");

        // reset in the middle of a job
        do_reset();
        out_ready = 1'b1;
        pulse_start();
        wait_wave(4'd7, "mid");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("mid_rst");
        clear_logs();
        pulse_start();
        chk("mid_restart_start", 64'(ext_start), 64'd1);
        chk("mid_restart_cycle", 64'(ext_cycle), 64'd0);
        wait_done(400, "mid");
        check_job("mid");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
